// File: rtl/dot_matrix_pkg.sv
// Shared geometry defaults, blank-output constants and the row-select helper
// for the dot matrix scanner and its frame buffer.
package dot_matrix_pkg;

    localparam int DEF_ROWS         = 8;
    localparam int DEF_COLS         = 8;
    localparam int DEF_BRIGHT_W     = 3;
    localparam int DEF_DWELL_LOG2   = 4;
    localparam int DEF_BLINK_FRAMES = 32;

    localparam int MAX_ROWS  = 16;
    localparam int MAX_COLS  = 32;
    localparam int MAX_ROW_W = 4;

    localparam logic [MAX_ROWS-1:0] BLANK_ROW = '1;
    localparam logic [MAX_COLS-1:0] BLANK_COL = '0;

    // Active-low one-hot-zero row select at the widest supported geometry.
    function automatic logic [MAX_ROWS-1:0] row_select_n(input logic [MAX_ROW_W-1:0] row);
        return ~(MAX_ROWS'(1) << row);
    endfunction

endpackage

// File: rtl/dot_matrix_frame_buffer.sv
// Double-buffered frame store: the back buffer takes controller writes and the
// front buffer feeds the scan. A commit copies back to front at a frame boundary.
module dot_matrix_frame_buffer
    import dot_matrix_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    i_wr_en,
    input  logic [$clog2(ROWS)-1:0] i_wr_row,
    input  logic [COLS-1:0]         i_wr_data,
    input  logic                    i_commit,
    input  logic                    i_copy_ok,
    input  logic [$clog2(ROWS)-1:0] i_rd_row,
    output logic [COLS-1:0]         o_rd_data,
    output logic                    o_commit_busy,
    output logic                    o_commit_done
);

    localparam int                ROW_W    = $clog2(ROWS);
    localparam logic [ROW_W:0]    ROWS_EXT = (ROW_W + 1)'(ROWS);

    logic [COLS-1:0] r_back  [ROWS];
    logic [COLS-1:0] r_front [ROWS];
    logic            r_pending;
    logic            r_done;
    logic            w_copy;
    logic            w_wr_ok;

    assign w_copy  = r_pending & i_copy_ok;
    assign w_wr_ok = i_wr_en & ({1'b0, i_wr_row} < ROWS_EXT);

    // NOTE: both arrays take the async reset so a reset always leaves a known zero frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ROWS; i++) begin
                r_back[i] <= '0;
            end
        end else if (w_wr_ok) begin
            r_back[i_wr_row] <= i_wr_data;
        end
    end

    // NOTE: non-blocking updates mean a write landing in the copy cycle is not seen by the copy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ROWS; i++) begin
                r_front[i] <= '0;
            end
        end else if (w_copy) begin
            r_front <= r_back;
        end
    end

    // A commit arriving in the copy cycle re-arms for the following frame.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_copy;
            if (w_copy) begin
                r_pending <= i_commit;
            end else if (i_commit) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign o_rd_data     = r_front[i_rd_row];
    assign o_commit_busy = r_pending;
    assign o_commit_done = r_done;

endmodule

// File: rtl/dot_matrix_scanner.sv
// Row-scanning LED dot matrix driver with PWM brightness, blink, blanking and a
// frame-synchronous commit of the double-buffered frame store.
module dot_matrix_scanner
    import dot_matrix_pkg::*;
#(
    parameter int ROWS         = DEF_ROWS,
    parameter int COLS         = DEF_COLS,
    parameter int BRIGHT_W     = DEF_BRIGHT_W,
    parameter int DWELL_LOG2   = DEF_DWELL_LOG2,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    wr_en,
    input  logic [$clog2(ROWS)-1:0] wr_row,
    input  logic [COLS-1:0]         wr_data,
    input  logic                    commit,
    output logic                    commit_busy,
    output logic                    commit_done,
    input  logic [BRIGHT_W-1:0]     brightness,
    input  logic                    blink_en,
    output logic                    frame_start,
    output logic [ROWS-1:0]         dot_row,
    output logic [COLS-1:0]         dot_col
);

    localparam int                  ROW_W      = $clog2(ROWS);
    localparam int                  BLINK_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [ROW_W-1:0]    LAST_ROW   = ROW_W'(ROWS - 1);
    localparam logic [BLINK_W-1:0]  LAST_BLINK = BLINK_W'(BLINK_FRAMES - 1);

    logic [DWELL_LOG2-1:0] r_dwell;
    logic [ROW_W-1:0]      r_row;
    logic [BLINK_W-1:0]    r_blink_cnt;
    logic                  r_blink_phase;
    logic [ROWS-1:0]       r_dot_row;
    logic [COLS-1:0]       r_dot_col;
    logic                  r_frame_start;

    logic                  w_dwell_last;
    logic                  w_frame_end;
    logic                  w_copy_ok;
    logic                  w_visible;
    logic [ROWS-1:0]       w_row_sel_n;
    logic [COLS-1:0]       w_front_row;

    assign w_dwell_last = &r_dwell;
    assign w_frame_end  = enable & w_dwell_last & (r_row == LAST_ROW);
    assign w_copy_ok    = w_frame_end | ~enable;
    assign w_visible    = enable
                        & (r_dwell[DWELL_LOG2-1 -: BRIGHT_W] <= brightness)
                        & ~(blink_en & r_blink_phase);
    assign w_row_sel_n  = ROWS'(row_select_n(MAX_ROW_W'(r_row)));

    dot_matrix_frame_buffer #(
        .ROWS (ROWS),
        .COLS (COLS)
    ) u_frame_buffer (
        .clock         (clock),
        .reset_n       (reset_n),
        .i_wr_en       (wr_en),
        .i_wr_row      (wr_row),
        .i_wr_data     (wr_data),
        .i_commit      (commit),
        .i_copy_ok     (w_copy_ok),
        .i_rd_row      (r_row),
        .o_rd_data     (w_front_row),
        .o_commit_busy (commit_busy),
        .o_commit_done (commit_done)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dwell <= '0;
            r_row   <= '0;
        end else if (enable) begin
            r_dwell <= r_dwell + 1'b1;
            if (w_dwell_last) begin
                r_row <= (r_row == LAST_ROW) ? '0 : r_row + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (!blink_en) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_frame_end) begin
            if (r_blink_cnt == LAST_BLINK) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // The last dwell clock of every row is always blanked, giving the
    // one-cycle anti-ghosting gap whenever that clock would have been lit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dot_row     <= ROWS'(BLANK_ROW);
            r_dot_col     <= COLS'(BLANK_COL);
            r_frame_start <= 1'b0;
        end else begin
            if (w_visible && !w_dwell_last) begin
                r_dot_row <= w_row_sel_n;
                r_dot_col <= w_front_row;
            end else begin
                r_dot_row <= ROWS'(BLANK_ROW);
                r_dot_col <= COLS'(BLANK_COL);
            end
            r_frame_start <= enable & (r_row == '0) & (r_dwell == '0);
        end
    end

    assign dot_row     = r_dot_row;
    assign dot_col     = r_dot_col;
    assign frame_start = r_frame_start;

endmodule

// File: tb/tb_dot_matrix_scanner.sv
// Directed bench for dot_matrix_scanner at 8x8, 16 clocks per row, blink every 2 frames.
module tb_dot_matrix_scanner;

    localparam int ROWS         = 8;
    localparam int COLS         = 8;
    localparam int BRIGHT_W     = 3;
    localparam int DWELL_LOG2   = 4;
    localparam int BLINK_FRAMES = 2;

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic       wr_en;
    logic [2:0] wr_row;
    logic [7:0] wr_data;
    logic       commit;
    logic       commit_busy;
    logic       commit_done;
    logic [2:0] brightness;
    logic       blink_en;
    logic       frame_start;
    logic [7:0] dot_row;
    logic [7:0] dot_col;

    typedef struct {
        int         p;
        logic [2:0] bright;
        logic [7:0] row;
        logic [7:0] col;
        logic       fs;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] g_pat [8];
    logic       exp_lit [7];
    int         n_cmp;
    int         n_err;
    int         cur_p;
    int         early;
    int         stale;
    int         guard;

    dot_matrix_scanner #(
        .ROWS         (ROWS),
        .COLS         (COLS),
        .BRIGHT_W     (BRIGHT_W),
        .DWELL_LOG2   (DWELL_LOG2),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .wr_en       (wr_en),
        .wr_row      (wr_row),
        .wr_data     (wr_data),
        .commit      (commit),
        .commit_busy (commit_busy),
        .commit_done (commit_done),
        .brightness  (brightness),
        .blink_en    (blink_en),
        .frame_start (frame_start),
        .dot_row     (dot_row),
        .dot_col     (dot_col)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // cur_p tracks the scan position shown on the outputs after the last enabled edge.
    task automatic tick();
        logic en;
        en = enable;
        @(posedge clock);
        #1;
        if (en && reset_n) cur_p++;
    endtask

    task automatic run_to(input int m);
        int g;
        g = 0;
        do begin
            tick();
            g++;
        end while (((cur_p % 128) != m) && (g < 400));
        check($sformatf("run_to_%0d_bound", m), 32'((cur_p % 128) == m), 32'd1);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; cur_p = -1;
        reset_n = 1'b0; enable = 1'b0; wr_en = 1'b0; wr_row = '0; wr_data = '0;
        commit = 1'b0; brightness = '0; blink_en = 1'b0;
        g_pat = '{8'h0C, 8'h12, 8'h20, 8'h2E, 8'h22, 8'h12, 8'h0C, 8'h81};
        exp_lit = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

        vecs.push_back('{  0, 3'd7, 8'hFE, 8'h0C, 1'b1});
        vecs.push_back('{  1, 3'd7, 8'hFE, 8'h0C, 1'b0});
        vecs.push_back('{ 14, 3'd7, 8'hFE, 8'h0C, 1'b0});
        vecs.push_back('{ 15, 3'd7, 8'hFF, 8'h00, 1'b0});
        vecs.push_back('{ 16, 3'd7, 8'hFD, 8'h12, 1'b0});
        vecs.push_back('{ 31, 3'd7, 8'hFF, 8'h00, 1'b0});
        vecs.push_back('{ 32, 3'd7, 8'hFB, 8'h20, 1'b0});
        vecs.push_back('{112, 3'd7, 8'h7F, 8'h81, 1'b0});
        vecs.push_back('{126, 3'd7, 8'h7F, 8'h81, 1'b0});
        vecs.push_back('{127, 3'd7, 8'hFF, 8'h00, 1'b0});
        vecs.push_back('{128, 3'd0, 8'hFE, 8'h0C, 1'b1});
        vecs.push_back('{129, 3'd0, 8'hFE, 8'h0C, 1'b0});
        vecs.push_back('{130, 3'd0, 8'hFF, 8'h00, 1'b0});
        vecs.push_back('{143, 3'd0, 8'hFF, 8'h00, 1'b0});
        vecs.push_back('{144, 3'd0, 8'hFD, 8'h12, 1'b0});
        vecs.push_back('{145, 3'd0, 8'hFD, 8'h12, 1'b0});
        vecs.push_back('{146, 3'd0, 8'hFF, 8'h00, 1'b0});
        vecs.push_back('{256, 3'd3, 8'hFE, 8'h0C, 1'b1});
        vecs.push_back('{304, 3'd3, 8'hF7, 8'h2E, 1'b0});
        vecs.push_back('{311, 3'd3, 8'hF7, 8'h2E, 1'b0});
        vecs.push_back('{312, 3'd3, 8'hFF, 8'h00, 1'b0});
        vecs.push_back('{319, 3'd3, 8'hFF, 8'h00, 1'b0});
        vecs.push_back('{320, 3'd3, 8'hEF, 8'h22, 1'b0});

        // Reset values.
        repeat (2) @(posedge clock);
        #1;
        check("rst_row", 32'(dot_row), 32'hFF);
        check("rst_col", 32'(dot_col), 32'h00);
        check("rst_busy", 32'(commit_busy), 32'd0);
        check("rst_done", 32'(commit_done), 32'd0);
        check("rst_fs", 32'(frame_start), 32'd0);
        reset_n = 1'b1;

        // Load the pattern while disabled; the commit copies on the next clock.
        for (int r = 0; r < 8; r++) begin
            wr_en = 1'b1; wr_row = 3'(r); wr_data = g_pat[r];
            tick();
        end
        wr_en = 1'b0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("dis_commit_busy", 32'(commit_busy), 32'd1);
        check("dis_commit_done_early", 32'(commit_done), 32'd0);
        check("dis_blank_row", 32'(dot_row), 32'hFF);
        tick();
        check("dis_copy_busy", 32'(commit_busy), 32'd0);
        check("dis_copy_done", 32'(commit_done), 32'd1);
        tick();
        check("dis_done_pulse", 32'(commit_done), 32'd0);

        // Table-driven scan, PWM and anti-ghosting vectors.
        enable = 1'b1;
        foreach (vecs[k]) begin
            brightness = vecs[k].bright;
            while (cur_p < vecs[k].p) tick();
            check($sformatf("vec%0d_row", k), 32'(dot_row), 32'(vecs[k].row));
            check($sformatf("vec%0d_col", k), 32'(dot_col), 32'(vecs[k].col));
            check($sformatf("vec%0d_fs", k), 32'(frame_start), 32'(vecs[k].fs));
        end

        // Mid-frame commit of an all-ones frame, with a repeat request while pending.
        brightness = 3'd7;
        for (int r = 0; r < 8; r++) begin
            wr_en = 1'b1; wr_row = 3'(r); wr_data = 8'hFF;
            tick();
        end
        wr_en = 1'b0;
        commit = 1'b1;
        tick();
        check("mid_commit_busy", 32'(commit_busy), 32'd1);
        early = 0; stale = 0; guard = 0;
        while (((cur_p % 128) != 127) && (guard < 200)) begin
            tick();
            commit = 1'b0;
            guard++;
            if ((cur_p % 128) != 127) begin
                if (!commit_busy || commit_done) early++;
                if (((cur_p % 16) == 0) && (dot_col !== g_pat[(cur_p % 128) / 16])) stale++;
            end
        end
        commit = 1'b0;
        check("mid_wait_bound", 32'((cur_p % 128) == 127), 32'd1);
        check("mid_early_release", 32'(early), 32'd0);
        check("mid_front_stale", 32'(stale), 32'd0);
        check("mid_copy_busy", 32'(commit_busy), 32'd0);
        check("mid_copy_done", 32'(commit_done), 32'd1);
        tick();
        check("mid_done_pulse", 32'(commit_done), 32'd0);
        check("mid_new_row", 32'(dot_row), 32'hFE);
        check("mid_new_col", 32'(dot_col), 32'hFF);
        check("mid_new_fs", 32'(frame_start), 32'd1);

        // Write to row 2 in the copy cycle.
        wr_en = 1'b1; wr_row = 3'd2; wr_data = 8'h33;
        tick();
        wr_en = 1'b0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        run_to(126);
        wr_en = 1'b1; wr_row = 3'd2; wr_data = 8'h5A;
        tick();
        wr_en = 1'b0;
        check("wcopy_done", 32'(commit_done), 32'd1);
        run_to(32);
        check("wcopy_row2_row", 32'(dot_row), 32'hFB);
        check("wcopy_row2_old", 32'(dot_col), 32'h33);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        run_to(127);
        run_to(32);
        check("wcopy_row2_new", 32'(dot_col), 32'h5A);

        // Blink: two frames lit, two blank.
        run_to(127);
        blink_en = 1'b1;
        for (int f = 0; f < 7; f++) begin
            run_to(67);
            check($sformatf("blink_f%0d_row", f), 32'(dot_row), exp_lit[f] ? 32'hEF : 32'hFF);
        end
        blink_en = 1'b0;
        tick();
        check("blink_off_row", 32'(dot_row), 32'hEF);
        check("blink_off_col", 32'(dot_col), 32'hFF);

        // Enable low: blank, frozen, immediate commit; resume from held position.
        enable = 1'b0;
        tick();
        check("dis_mid_row", 32'(dot_row), 32'hFF);
        check("dis_mid_col", 32'(dot_col), 32'h00);
        wr_en = 1'b1; wr_row = 3'd0; wr_data = 8'h3C;
        tick();
        wr_en = 1'b0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("dis_mid_busy", 32'(commit_busy), 32'd1);
        tick();
        check("dis_mid_copy_busy", 32'(commit_busy), 32'd0);
        check("dis_mid_copy_done", 32'(commit_done), 32'd1);
        enable = 1'b1;
        tick();
        check("resume_pos", 32'(cur_p % 128), 32'd69);
        check("resume_row", 32'(dot_row), 32'hEF);
        check("resume_col", 32'(dot_col), 32'hFF);
        run_to(0);
        check("resume_row0_col", 32'(dot_col), 32'h3C);
        check("resume_fs", 32'(frame_start), 32'd1);

        // Reset mid-row with a commit pending.
        wr_en = 1'b1; wr_row = 3'd1; wr_data = 8'h55;
        tick();
        wr_en = 1'b0;
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("pre_rst_busy", 32'(commit_busy), 32'd1);
        check("pre_rst_row", 32'(dot_row), 32'hFE);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_row", 32'(dot_row), 32'hFF);
        check("async_rst_col", 32'(dot_col), 32'h00);
        check("async_rst_busy", 32'(commit_busy), 32'd0);
        tick();
        reset_n = 1'b1;
        cur_p = -1;
        tick();
        check("post_rst_row", 32'(dot_row), 32'hFE);
        check("post_rst_col", 32'(dot_col), 32'h00);
        check("post_rst_fs", 32'(frame_start), 32'd1);
        check("post_rst_busy", 32'(commit_busy), 32'd0);
        repeat (16) tick();
        check("post_rst_row1", 32'(dot_row), 32'hFD);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        run_to(127);
        run_to(16);
        check("post_rst_back_cleared", 32'(dot_col), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
